// File: rtl/project_types_pkg.sv
// ---------------------------------------------------------------------------
// project_types
// Shared types for the MIPS pipeline memory stage.
//   reset_status_t / RST_ENABLE : reset type and its asserted level (low)
//   mem_op_t                    : memory operation handed over by EX
//   mem_state_t                 : load/store unit bus FSM states
//   reg_t                       : {we, waddr, wdata} register write-back bundle
//   hilo_t                      : {we, hi, lo} HI/LO write-back bundle
// Helper functions classify an op as load/store and check its alignment.
// ---------------------------------------------------------------------------
package project_types;

   typedef logic reset_status_t;
   localparam reset_status_t RST_ENABLE = 1'b0;

   typedef enum logic [3:0] {
      MOP_NOP,
      MOP_LB,
      MOP_LBU,
      MOP_LH,
      MOP_LHU,
      MOP_LW,
      MOP_SB,
      MOP_SH,
      MOP_SW
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE,
      DRAIN
   } mem_state_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } reg_t;

   typedef struct packed {
      logic        we;
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   function automatic logic is_load(input mem_op_t op);
      return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
             (op == MOP_LHU) || (op == MOP_LW);
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
   endfunction

   // Halfwords need an even address, words need a multiple of four.
   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lsb);
      logic bad;
      bad = 1'b0;
      case (op)
         MOP_LH, MOP_LHU, MOP_SH: bad = lsb[0];
         MOP_LW, MOP_SW:          bad = (lsb != 2'b00);
         default:                 bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Picks the byte/halfword lane of a loaded bus word and sign- or
// zero-extends it to 32 bits. Kept separate so unaligned-load variants
// (LWL/LWR) can reuse the lane logic later.
//   op   : load operation (LB/LBU/LH/LHU/LW; others pass the word through)
//   lane : low two address bits selecting the lane
//   word : raw 32-bit word from the data bus
//   data : extended load result
// ---------------------------------------------------------------------------
module load_extend
   import project_types::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Little-endian lanes: byte n lives in bits [8n+7:8n].
   always_comb begin
      byte_v = word[7:0];
      case (lane)
         2'd0: byte_v = word[7:0];
         2'd1: byte_v = word[15:8];
         2'd2: byte_v = word[23:16];
         2'd3: byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      half_v = lane[1] ? word[31:16] : word[15:0];

      data = word;
      case (op)
         MOP_LB:  data = {{24{byte_v[7]}}, byte_v};
         MOP_LBU: data = {24'h000000, byte_v};
         MOP_LH:  data = {{16{half_v[15]}}, half_v};
         MOP_LHU: data = {16'h0000, half_v};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Memory-stage load/store unit. Turns the EX/MEM memory op into a req/ack
// data-bus transaction, holds the pipeline with stallreq until it completes,
// and drives the write-back bundles registered by MEM/WB.
//   clk, rst            : clock, asynchronous active-low reset
//   stall, flush        : pipeline stall vector (bit 4 = MEM held), flush
//   ex_mem_op/addr      : memory op and effective address from EX
//   ex_store_data       : store source value
//   ex_wreg, ex_hilo    : write-back bundles from EX
//   bus_req/we/sel/addr/wdata : registered bus request side
//   bus_rdata, bus_ack  : bus response side
//   mem_wreg_o, mem_hilo_o : write-back bundles to MEM/WB
//   stallreq            : hold stages 0..4
//   exc_adel/exc_ades/bad_addr : address error reporting
// ---------------------------------------------------------------------------
module mem_access
   import project_types::*;
#(
   parameter int ADDR_W = 32
)(
   input  logic              clk,
   input  reset_status_t     rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  mem_op_t           ex_mem_op,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [31:0]       ex_store_data,
   input  reg_t              ex_wreg,
   input  hilo_t             ex_hilo,
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack,
   output reg_t              mem_wreg_o,
   output hilo_t             mem_hilo_o,
   output logic              stallreq,
   output logic              exc_adel,
   output logic              exc_ades,
   output logic [ADDR_W-1:0] bad_addr
);

   mem_state_t  state;
   mem_state_t  state_next;
   logic [31:0] rdata_q;
   logic [31:0] load_data;
   logic        mem_op;
   logic        misaligned;
   logic        start_req;
   logic [3:0]  sel_calc;
   logic [31:0] wdata_calc;
   logic        unused_stall;

   // Only the MEM-stage hold bit matters here.
   assign unused_stall = ^{stall[5], stall[3:0]};

   assign mem_op     = (ex_mem_op != MOP_NOP);
   assign misaligned = is_misaligned(ex_mem_op, ex_mem_addr[1:0]);
   assign start_req  = (state == IDLE) && mem_op && !misaligned && !flush;

   load_extend u_load_extend (
      .op   (ex_mem_op),
      .lane (ex_mem_addr[1:0]),
      .word (rdata_q),
      .data (load_data)
   );

   // Byte enables and replicated store data, so the addressed lane always
   // carries the store value whatever the slave's lane wiring.
   always_comb begin
      sel_calc   = 4'b1111;
      wdata_calc = ex_store_data;
      case (ex_mem_op)
         MOP_LB, MOP_LBU, MOP_SB: sel_calc = 4'b0001 << ex_mem_addr[1:0];
         MOP_LH, MOP_LHU, MOP_SH: sel_calc = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
         default:                 sel_calc = 4'b1111;
      endcase
      case (ex_mem_op)
         MOP_SB:  wdata_calc = {4{ex_store_data[7:0]}};
         MOP_SH:  wdata_calc = {2{ex_store_data[15:0]}};
         default: wdata_calc = ex_store_data;
      endcase
   end

   // FSM state register; reset abandons any outstanding transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Bus request registers and read-data capture. The request is loaded on
   // the way out of IDLE and torn down on the ack, whether the cycle was
   // completing normally (REQ) or being drained after a flush (DRAIN).
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= 4'b0000;
         bus_addr  <= '0;
         bus_wdata <= 32'h0;
         rdata_q   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (start_req) begin
                  bus_req   <= 1'b1;
                  bus_we    <= is_store(ex_mem_op);
                  bus_sel   <= sel_calc;
                  bus_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
                  bus_wdata <= wdata_calc;
               end
            end
            REQ, DRAIN: begin
               if (bus_ack) begin
                  rdata_q <= bus_rdata;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  bus_sel <= 4'b0000;
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and all write-back/stall/exception outputs. A flush that
   // coincides with the ack in REQ has nothing left to drain, so it goes
   // straight back to IDLE instead of waiting for an ack that never comes.
   always_comb begin
      state_next = state;
      stallreq   = 1'b0;
      mem_wreg_o = ex_wreg;
      mem_hilo_o = ex_hilo;
      exc_adel   = 1'b0;
      exc_ades   = 1'b0;
      bad_addr   = '0;

      case (state)
         IDLE: begin
            if (mem_op) begin
               mem_wreg_o.we = 1'b0;
               if (misaligned) begin
                  exc_adel = is_load(ex_mem_op);
                  exc_ades = is_store(ex_mem_op);
                  bad_addr = ex_mem_addr;
               end else begin
                  mem_hilo_o.we = 1'b0;
                  if (!flush) begin
                     stallreq   = 1'b1;
                     state_next = REQ;
                  end
               end
            end
         end
         REQ: begin
            stallreq      = 1'b1;
            mem_wreg_o.we = 1'b0;
            mem_hilo_o.we = 1'b0;
            if (bus_ack) begin
               state_next = flush ? IDLE : DONE;
            end else if (flush) begin
               state_next = DRAIN;
            end
         end
         DONE: begin
            if (is_load(ex_mem_op)) begin
               mem_wreg_o.wdata = load_data;
            end
            if (!stall[4] || flush) begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            stallreq      = 1'b1;
            mem_wreg_o.we = 1'b0;
            mem_hilo_o.we = 1'b0;
            if (bus_ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (flush) begin
         mem_wreg_o.we = 1'b0;
         mem_hilo_o.we = 1'b0;
      end

      if (rst == RST_ENABLE) begin
         stallreq   = 1'b0;
         mem_wreg_o = '0;
         mem_hilo_o = '0;
         exc_adel   = 1'b0;
         exc_ades   = 1'b0;
         bad_addr   = '0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access: a table of aligned loads/stores with
// hand-derived bus fields and results, plus hand-written sequences for reset,
// pass-through, misalignment, flush and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_mem_access;
   import project_types::*;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   reset_status_t     rst;
   logic [5:0]        stall;
   logic              flush;
   mem_op_t           ex_mem_op;
   logic [ADDR_W-1:0] ex_mem_addr;
   logic [31:0]       ex_store_data;
   reg_t              ex_wreg;
   hilo_t             ex_hilo;
   logic              bus_req;
   logic              bus_we;
   logic [3:0]        bus_sel;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic [31:0]       bus_rdata;
   logic              bus_ack;
   reg_t              mem_wreg_o;
   hilo_t             mem_hilo_o;
   logic              stallreq;
   logic              exc_adel;
   logic              exc_ades;
   logic [ADDR_W-1:0] bad_addr;

   mem_access #(.ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .ex_mem_op     (ex_mem_op),
      .ex_mem_addr   (ex_mem_addr),
      .ex_store_data (ex_store_data),
      .ex_wreg       (ex_wreg),
      .ex_hilo       (ex_hilo),
      .bus_req       (bus_req),
      .bus_we        (bus_we),
      .bus_sel       (bus_sel),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .bus_ack       (bus_ack),
      .mem_wreg_o    (mem_wreg_o),
      .mem_hilo_o    (mem_hilo_o),
      .stallreq      (stallreq),
      .exc_adel      (exc_adel),
      .exc_ades      (exc_ades),
      .bad_addr      (bad_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      mem_op_t     op;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  waddr;
      logic        wregWe;
      int          waitCycles;
      logic [31:0] rdata;
      logic [3:0]  expSel;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
      logic        expWe;
      logic [31:0] expResult;
   } vec_t;

   typedef struct {
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      reg_t        wreg;
      int          stallCycles;
      int          reqCycles;
   } exp_t;

   localparam logic [31:0] FILLER = 32'h1111_1111;

   exp_t expQ[$];
   vec_t vecs[10];
   int   checks = 0;
   int   errors = 0;

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input mem_op_t op, input logic [31:0] addr,
                                input logic [31:0] sdata, input reg_t wreg, input logic fl);
      ex_mem_op     = op;
      ex_mem_addr   = addr;
      ex_store_data = sdata;
      ex_wreg       = wreg;
      flush         = fl;
   endtask

   // One aligned transaction: expectations go into the scoreboard when the
   // op is driven and are popped when the DUT raises bus_req.
   task automatic runVector(input vec_t v, input int idx);
      exp_t e;
      exp_t got;
      reg_t w;
      int   stallCount;
      int   reqCount;
      bit   seen;
      @(negedge clk);
      e.sel         = v.expSel;
      e.addr        = v.expAddr;
      e.wdata       = v.expWdata;
      e.we          = v.expWe;
      e.wreg        = '{we: v.wregWe, waddr: v.waddr, wdata: v.expResult};
      e.stallCycles = v.waitCycles + 2;
      e.reqCycles   = v.waitCycles + 1;
      expQ.push_back(e);
      w = '{we: v.wregWe, waddr: v.waddr, wdata: FILLER};
      applyStimulus(v.op, v.addr, v.sdata, w, 1'b0);
      #1;
      stallCount = stallreq ? 1 : 0;
      checkOutput($sformatf("v%0d_cyc0_req", idx), 72'(bus_req), 72'(1'b0));
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (stallreq) stallCount++;
         if (bus_req) seen = 1'b1;
      end
      got = expQ.pop_front();
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL v%0d_req_timeout actual=0 required=1", idx);
         applyStimulus(MOP_NOP, 32'h0, 32'h0, '0, 1'b0);
         return;
      end
      checkOutput($sformatf("v%0d_sel", idx),   72'(bus_sel),   72'(got.sel));
      checkOutput($sformatf("v%0d_addr", idx),  72'(bus_addr),  72'(got.addr));
      checkOutput($sformatf("v%0d_wdata", idx), 72'(bus_wdata), 72'(got.wdata));
      checkOutput($sformatf("v%0d_we", idx),    72'(bus_we),    72'(got.we));
      reqCount = 1;
      for (int c = 0; c < v.waitCycles; c++) begin
         @(negedge clk);
         #1;
         if (stallreq) stallCount++;
         if (bus_req) reqCount++;
      end
      checkOutput($sformatf("v%0d_addr_held", idx), 72'(bus_addr), 72'(got.addr));
      bus_ack   = 1'b1;
      bus_rdata = v.rdata;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      #1;
      checkOutput($sformatf("v%0d_done_stallreq", idx), 72'(stallreq), 72'(1'b0));
      checkOutput($sformatf("v%0d_done_busreq", idx), 72'(bus_req), 72'(1'b0));
      checkOutput($sformatf("v%0d_result", idx), 72'(mem_wreg_o), 72'(got.wreg));
      checkOutput($sformatf("v%0d_stall_cycles", idx), 72'(stallCount), 72'(got.stallCycles));
      checkOutput($sformatf("v%0d_req_cycles", idx), 72'(reqCount), 72'(got.reqCycles));
      applyStimulus(MOP_NOP, 32'h0, 32'h0, '0, 1'b0);
   endtask

   initial begin
      reg_t addu;
      vecs[0] = '{MOP_LB,  32'h103, 32'h0,         5'd3,  1'b1, 0, 32'h80FF_FFFF, 4'b1000, 32'h100, 32'h0,         1'b0, 32'hFFFF_FF80};
      vecs[1] = '{MOP_LHU, 32'h102, 32'h0,         5'd7,  1'b1, 4, 32'hBEEF_1234, 4'b1100, 32'h100, 32'h0,         1'b0, 32'h0000_BEEF};
      vecs[2] = '{MOP_SB,  32'h201, 32'h0000_00A5, 5'd0,  1'b0, 1, 32'h0,         4'b0010, 32'h200, 32'hA5A5_A5A5, 1'b1, FILLER};
      vecs[3] = '{MOP_LH,  32'h106, 32'h0,         5'd9,  1'b1, 1, 32'h8001_7FFF, 4'b1100, 32'h104, 32'h0,         1'b0, 32'hFFFF_8001};
      vecs[4] = '{MOP_LBU, 32'h302, 32'h0,         5'd10, 1'b1, 0, 32'h12C3_4567, 4'b0100, 32'h300, 32'h0,         1'b0, 32'h0000_00C3};
      vecs[5] = '{MOP_LW,  32'h400, 32'h0,         5'd31, 1'b1, 2, 32'hDEAD_BEEF, 4'b1111, 32'h400, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vecs[6] = '{MOP_SH,  32'h502, 32'h1234_ABCD, 5'd0,  1'b0, 0, 32'h0,         4'b1100, 32'h500, 32'hABCD_ABCD, 1'b1, FILLER};
      vecs[7] = '{MOP_SW,  32'h600, 32'hCAFE_F00D, 5'd0,  1'b0, 3, 32'h0,         4'b1111, 32'h600, 32'hCAFE_F00D, 1'b1, FILLER};
      vecs[8] = '{MOP_LB,  32'h100, 32'h0,         5'd1,  1'b1, 0, 32'h0000_007F, 4'b0001, 32'h100, 32'h0,         1'b0, 32'h0000_007F};
      vecs[9] = '{MOP_LH,  32'h200, 32'h0,         5'd2,  1'b1, 0, 32'h1234_8000, 4'b0011, 32'h200, 32'h0,         1'b0, 32'hFFFF_8000};

      addu      = '{we: 1'b1, waddr: 5'd5, wdata: 32'h0000_1234};
      rst       = RST_ENABLE;
      stall     = 6'b0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      ex_hilo   = '{we: 1'b1, hi: 32'hAAAA_0000, lo: 32'h0000_BBBB};
      applyStimulus(MOP_NOP, 32'h0, 32'h0, addu, 1'b0);

      // Reset state: everything quiet even with a live write-back at the input.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_bus_req",  72'(bus_req),    72'(1'b0));
      checkOutput("rst_stallreq", 72'(stallreq),   72'(1'b0));
      checkOutput("rst_wreg",     72'(mem_wreg_o), 72'(0));
      checkOutput("rst_hilo",     72'(mem_hilo_o), 72'(0));
      checkOutput("rst_exc",      72'({exc_adel, exc_ades}), 72'(0));

      // NOP pass-through in the same cycle.
      @(negedge clk);
      rst = ~RST_ENABLE;
      #1;
      checkOutput("nop_wreg",     72'(mem_wreg_o), 72'(addu));
      checkOutput("nop_hilo",     72'(mem_hilo_o), 72'({1'b1, 32'hAAAA_0000, 32'h0000_BBBB}));
      checkOutput("nop_stallreq", 72'(stallreq),   72'(1'b0));

      for (int i = 0; i < 10; i++) begin
         runVector(vecs[i], i);
      end

      // Misaligned load and store.
      @(negedge clk);
      applyStimulus(MOP_LW, 32'h102, 32'h0, addu, 1'b0);
      #1;
      checkOutput("lw_mis_adel",     72'(exc_adel),      72'(1'b1));
      checkOutput("lw_mis_ades",     72'(exc_ades),      72'(1'b0));
      checkOutput("lw_mis_bad_addr", 72'(bad_addr),      72'(32'h102));
      checkOutput("lw_mis_we",       72'(mem_wreg_o.we), 72'(1'b0));
      checkOutput("lw_mis_stallreq", 72'(stallreq),      72'(1'b0));
      @(negedge clk);
      #1;
      checkOutput("lw_mis_no_req",   72'(bus_req),       72'(1'b0));
      applyStimulus(MOP_SH, 32'h101, 32'h0, '0, 1'b0);
      #1;
      checkOutput("sh_mis_ades",     72'(exc_ades),      72'(1'b1));
      checkOutput("sh_mis_adel",     72'(exc_adel),      72'(1'b0));
      checkOutput("sh_mis_bad_addr", 72'(bad_addr),      72'(32'h101));
      @(negedge clk);
      applyStimulus(MOP_NOP, 32'h0, 32'h0, addu, 1'b0);
      #1;
      checkOutput("sh_mis_no_req",   72'(bus_req),       72'(1'b0));
      checkOutput("nop_bad_addr",    72'(bad_addr),      72'(0));

      // Flush in IDLE: no request starts and the write-back is suppressed.
      @(negedge clk);
      applyStimulus(MOP_LW, 32'h400, 32'h0, addu, 1'b1);
      #1;
      checkOutput("idle_flush_stallreq", 72'(stallreq), 72'(1'b0));
      checkOutput("idle_flush_we",       72'(mem_wreg_o.we), 72'(1'b0));
      @(negedge clk);
      applyStimulus(MOP_NOP, 32'h0, 32'h0, addu, 1'b0);
      #1;
      checkOutput("idle_flush_no_req",   72'(bus_req), 72'(1'b0));

      // Flush in REQ: the bus cycle drains until its ack, no write-back.
      @(negedge clk);
      applyStimulus(MOP_LW, 32'h700, 32'h0, addu, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("drain_req_up", 72'(bus_req), 72'(1'b1));
      applyStimulus(MOP_NOP, 32'h0, 32'h0, addu, 1'b1);
      #1;
      checkOutput("drain_flush_we", 72'(mem_wreg_o.we), 72'(1'b0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         flush = 1'b0;
         #1;
         checkOutput($sformatf("drain_c%0d_req", c),      72'(bus_req),       72'(1'b1));
         checkOutput($sformatf("drain_c%0d_stallreq", c), 72'(stallreq),      72'(1'b1));
         checkOutput($sformatf("drain_c%0d_we", c),       72'(mem_wreg_o.we), 72'(1'b0));
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      #1;
      checkOutput("drain_end_req",      72'(bus_req),    72'(1'b0));
      checkOutput("drain_end_stallreq", 72'(stallreq),   72'(1'b0));
      checkOutput("drain_end_wreg",     72'(mem_wreg_o), 72'(addu));

      // Asynchronous reset in the middle of REQ.
      @(negedge clk);
      applyStimulus(MOP_LB, 32'h800, 32'h0, addu, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("rstreq_req_up", 72'(bus_req), 72'(1'b1));
      @(negedge clk);
      rst = RST_ENABLE;
      #1;
      checkOutput("rstreq_req_drop", 72'(bus_req),  72'(1'b0));
      checkOutput("rstreq_stallreq", 72'(stallreq), 72'(1'b0));
      @(negedge clk);
      rst = ~RST_ENABLE;
      applyStimulus(MOP_NOP, 32'h0, 32'h0, addu, 1'b0);
      #1;
      checkOutput("rstreq_idle_stallreq", 72'(stallreq), 72'(1'b0));
      @(negedge clk);
      #1;
      checkOutput("rstreq_idle_req",  72'(bus_req),    72'(1'b0));
      checkOutput("rstreq_idle_wreg", 72'(mem_wreg_o), 72'(addu));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
